// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU SPI transmit path: FSM encoding and byte constants.
package ccu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    localparam logic [7:0] IDLE_BYTE_DEF    = 8'hFF;
    localparam logic [7:0] FRAME_START_BYTE = 8'h5A;

endpackage

// File: rtl/ccu_sync_edge.sv
// N-stage synchroniser for an asynchronous pin plus single-cycle rise/fall pulses.
module ccu_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/ccu_spi_tx.sv
// SPI-slave (mode 0, MSB first) transmitter fed from AXI4-Stream through a one-byte holding register.
module ccu_spi_tx
    import ccu_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [7:0] IDLE_BYTE      = IDLE_BYTE_DEF,
    parameter int         UNDERRUN_CNT_W = 16
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    output logic                      tx_active,
    output logic                      tx_byte_done,
    output logic                      tx_frame_done,
    output logic                      tx_abort,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    ccu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(axi_aclk), .rst_i(axi_areset), .async_i(spi_sclk),
        .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    ccu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(axi_aclk), .rst_i(axi_areset), .async_i(spi_cs_n),
        .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_state_e                state_q, state_d;
    logic                      hold_valid_q, hold_valid_d;
    logic [7:0]                hold_data_q, hold_data_d;
    logic                      hold_last_q, hold_last_d;
    logic [7:0]                shift_q, shift_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic                      last_q, last_d;
    logic                      pend_q, pend_d;
    logic                      pend_hold_q, pend_hold_d;
    logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
    logic                      cs_act_q, cs_act_d;
    logic                      byte_done_q, byte_done_d;
    logic                      frame_done_q, frame_done_d;
    logic                      abort_q, abort_d;

    logic load_en, commit_en, commit_hold;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        last_d       = last_q;
        pend_d       = pend_q;
        pend_hold_d  = pend_hold_q;
        ucnt_d       = ucnt_q;
        cs_act_d     = cs_act_q;
        byte_done_d  = 1'b0;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;
        load_en      = 1'b0;
        commit_en    = 1'b0;
        commit_hold  = 1'b0;

        if (cs_fall)      cs_act_d = 1'b1;
        else if (cs_rise) cs_act_d = 1'b0;

        if (s_axis_tvalid && s_axis_tready) begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_axis_tdata;
            hold_last_d  = s_axis_tlast;
        end

        if (cs_rise) begin
            state_d   = ST_IDLE;
            abort_d   = (bit_cnt_q != 4'd0) && (bit_cnt_q != 4'd8);
            bit_cnt_d = 4'd0;
            pend_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 4'd0;
                    pend_d    = 1'b0;
                    if (cs_fall) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    load_en     = 1'b1;
                    commit_en   = 1'b1;
                    commit_hold = hold_valid_q;
                    bit_cnt_d   = 4'd0;
                    state_d     = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            byte_done_d  = 1'b1;
                            frame_done_d = last_q;
                        end
                        // A reload is only committed once the master clocks into the
                        // new byte, so the idle-low SCLK fall ending a frame loses nothing.
                        if (pend_q) begin
                            commit_en   = 1'b1;
                            commit_hold = pend_hold_q;
                            pend_d      = 1'b0;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            load_en     = 1'b1;
                            pend_d      = 1'b1;
                            pend_hold_d = hold_valid_q;
                            bit_cnt_d   = 4'd0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load_en) begin
            shift_d = hold_valid_q ? hold_data_q : IDLE_BYTE;
            last_d  = hold_valid_q & hold_last_q;
        end

        if (commit_en) begin
            if (commit_hold)                              hold_valid_d = 1'b0;
            else if (ucnt_q != {UNDERRUN_CNT_W{1'b1}})    ucnt_d       = ucnt_q + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_last_q  <= 1'b0;
            shift_q      <= IDLE_BYTE;
            bit_cnt_q    <= 4'd0;
            last_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_hold_q  <= 1'b0;
            ucnt_q       <= '0;
            cs_act_q     <= 1'b0;
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            last_q       <= last_d;
            pend_q       <= pend_d;
            pend_hold_q  <= pend_hold_d;
            ucnt_q       <= ucnt_d;
            cs_act_q     <= cs_act_d;
            byte_done_q  <= byte_done_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
        end
    end

    assign s_axis_tready = ~hold_valid_q & ~axi_areset;
    assign spi_miso      = shift_q[7];
    assign spi_miso_oe   = cs_act_q;
    assign tx_active     = cs_act_q;
    assign tx_byte_done  = byte_done_q;
    assign tx_frame_done = frame_done_q;
    assign tx_abort      = abort_q;
    assign underrun_cnt  = ucnt_q;

endmodule

// File: tb/tb_ccu_spi_tx.sv
// Bench for ccu_spi_tx: a mode-0 SPI master and AXIS source checked against a byte-queue model.
module tb_ccu_spi_tx;

    localparam int HP = 25;  // SCLK half period in clk cycles (50 MHz / 1 MHz)

    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0, tlast = 1'b0, tready;
    logic        sclk = 1'b0, cs_n = 1'b1;
    logic        miso, oe, act, bd, fd, ab;
    logic [15:0] ucnt;
    logic [7:0]  zero8 = 8'h00;
    logic        zero1 = 1'b0;
    logic        s_tready, s_miso, s_oe, s_act, s_bd, s_fd, s_ab;
    logic [1:0]  s_ucnt;

    always #10 clk = ~clk;

    ccu_spi_tx dut (
        .axi_aclk(clk), .axi_areset(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
        .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_miso(miso), .spi_miso_oe(oe),
        .tx_active(act), .tx_byte_done(bd), .tx_frame_done(fd), .tx_abort(ab),
        .underrun_cnt(ucnt)
    );

    // Narrow counter instance: shares the SPI pins, never fed, to exercise saturation.
    ccu_spi_tx #(.UNDERRUN_CNT_W(2)) dut_sat (
        .axi_aclk(clk), .axi_areset(rst),
        .s_axis_tdata(zero8), .s_axis_tvalid(zero1), .s_axis_tready(s_tready), .s_axis_tlast(zero1),
        .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_miso(s_miso), .spi_miso_oe(s_oe),
        .tx_active(s_act), .tx_byte_done(s_bd), .tx_frame_done(s_fd), .tx_abort(s_ab),
        .underrun_cnt(s_ucnt)
    );

    typedef struct { logic [7:0] d; logic last; } item_t;
    item_t axq[$];    // what the AXIS source still has to offer
    item_t exp_q[$];  // bytes accepted by the bench, not yet shifted out
    int    ur_exp = 0, fd_exp = 0;
    int    checks = 0, errors = 0;
    int    n_bd = 0, n_fd = 0, n_ab = 0, n_trdy0 = 0;

    always @(posedge clk) begin
        if (bd) n_bd <= n_bd + 1;
        if (fd) n_fd <= n_fd + 1;
        if (ab) n_ab <= n_ab + 1;
        if (!rst && !tready) n_trdy0 <= n_trdy0 + 1;
    end

    initial forever begin
        @(negedge clk);
        if (axq.size() > 0) begin
            tvalid = 1'b1; tdata = axq[0].d; tlast = axq[0].last;
        end else begin
            tvalid = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        if (tvalid && tready) void'(axq.pop_front());
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        item_t it;
        it.d = d; it.last = l;
        axq.push_back(it);
        exp_q.push_back(it);
    endtask

    // Every byte the master clocks into: next accepted byte, else an idle byte (underrun).
    task automatic model_take(output logic [7:0] b);
        item_t it;
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            b  = it.d;
            if (it.last) fd_exp++;
        end else begin
            b = 8'hFF;
            if (ur_exp < 65535) ur_exp++;
        end
    endtask

    task automatic cs_low();
        @(negedge clk); cs_n = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic spi_bits(input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            repeat (HP) @(negedge clk);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic byte_vs_model(input string nm);
        logic [7:0] rx, e;
        spi_bits(8, rx);
        model_take(e);
        chk(nm, {24'h0, rx}, {24'h0, e});
    endtask

    typedef struct {
        logic       push;
        logic [7:0] d;
        logic       last;
        logic [7:0] exp_b;
        int         exp_fd;
        int         exp_ur;
    } vec_t;

    initial begin
        vec_t       tbl[5];
        logic [7:0] exp3[3];
        logic [7:0] rx, e;
        int         fd0, bd0, ab0, ur0, t0, m, n;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 0, 0};
        tbl[1] = '{1'b1, 8'h00, 1'b1, 8'h00, 1, 0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 8'hFF, 0, 1};
        tbl[3] = '{1'b1, 8'h81, 1'b1, 8'h81, 1, 0};
        tbl[4] = '{1'b1, 8'h7E, 1'b0, 8'h7E, 0, 0};
        exp3[0] = 8'h5A; exp3[1] = 8'h34; exp3[2] = 8'h12;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'h0, miso}, 32'd1);
        chk("rst_oe", {31'h0, oe}, 32'd0);
        chk("rst_tready", {31'h0, tready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", {31'h0, tready}, 32'd1);
        chk("post_rst_active", {31'h0, act}, 32'd0);
        chk("post_rst_ucnt", {16'h0, ucnt}, 32'd0);

        // single-byte frames from a table
        for (int i = 0; i < 5; i++) begin
            fd0 = n_fd; ur0 = int'(ucnt);
            if (tbl[i].push) push(tbl[i].d, tbl[i].last);
            repeat (5) @(negedge clk);
            cs_low();
            chk("tbl_oe", {31'h0, oe}, 32'd1);
            spi_bits(8, rx);
            model_take(e);
            cs_high();
            chk("tbl_byte", {24'h0, rx}, {24'h0, tbl[i].exp_b});
            chk("tbl_frame_done", n_fd - fd0, tbl[i].exp_fd);
            chk("tbl_underrun", int'(ucnt) - ur0, tbl[i].exp_ur);
        end

        // three pre-loaded bytes, frame_done only on the last
        push(8'h5A, 1'b0); push(8'h34, 1'b0); push(8'h12, 1'b1);
        repeat (5) @(negedge clk);
        fd0 = n_fd; bd0 = n_bd;
        cs_low();
        for (int k = 0; k < 3; k++) begin
            spi_bits(8, rx);
            model_take(e);
            chk("frame3_byte", {24'h0, rx}, {24'h0, exp3[k]});
            chk("frame3_fd", n_fd - fd0, (k == 2) ? 1 : 0);
        end
        cs_high();
        chk("frame3_bd", n_bd - bd0, 3);

        // underrun with AXIS idle
        ur0 = int'(ucnt); t0 = n_trdy0;
        cs_low();
        byte_vs_model("underrun_byte0");
        byte_vs_model("underrun_byte1");
        cs_high();
        chk("underrun_cnt", int'(ucnt) - ur0, 2);
        chk("underrun_tready", n_trdy0 - t0, 0);

        // six-byte burst with tvalid held
        for (int k = 0; k < 6; k++) push(8'(8'h11 * (k + 1)), k == 5);
        repeat (5) @(negedge clk);
        ur0 = int'(ucnt); t0 = n_trdy0; fd0 = n_fd;
        cs_low();
        for (int k = 0; k < 6; k++) byte_vs_model("burst_byte");
        cs_high();
        chk("burst_tready_dropped", {31'h0, n_trdy0 > t0}, 32'd1);
        chk("burst_underrun", int'(ucnt) - ur0, 0);
        chk("burst_fd", n_fd - fd0, 1);

        // abort after three bits, next frame resumes with the following byte
        push(8'hA5, 1'b0); push(8'h3C, 1'b0);
        repeat (5) @(negedge clk);
        ab0 = n_ab; bd0 = n_bd;
        cs_low();
        spi_bits(3, rx);
        model_take(e);
        cs_high();
        chk("abort_bits", {24'h0, rx}, 32'h5);
        chk("abort_pulse", n_ab - ab0, 1);
        chk("abort_no_bd", n_bd - bd0, 0);
        cs_low();
        byte_vs_model("after_abort");
        cs_high();

        // randomized frames
        for (int it = 0; it < 12; it++) begin
            m = $urandom_range(0, 3);
            for (int k = 0; k < m; k++) push(8'($urandom), 1'($urandom));
            repeat (5) @(negedge clk);
            n = $urandom_range(1, 4);
            cs_low();
            for (int k = 0; k < n; k++) byte_vs_model("rand_byte");
            cs_high();
        end
        if (exp_q.size() > 0) begin
            n = exp_q.size();
            cs_low();
            for (int k = 0; k < n; k++) byte_vs_model("drain_byte");
            cs_high();
        end
        chk("total_underrun", {16'h0, ucnt}, ur_exp);
        chk("total_frame_done", n_fd, fd_exp);

        // reset in the middle of a byte
        push(8'h3C, 1'b0);
        repeat (5) @(negedge clk);
        cs_low();
        spi_bits(4, rx);
        model_take(e);
        ab0 = n_ab; bd0 = n_bd; fd0 = n_fd;
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ur_exp = 0;
        @(negedge clk);
        chk("midrst_tready", {31'h0, tready}, 32'd1);
        chk("midrst_oe", {31'h0, oe}, 32'd0);
        chk("midrst_ucnt", {16'h0, ucnt}, 32'd0);
        repeat (10) @(negedge clk);
        chk("midrst_no_pulse", (n_ab - ab0) + (n_bd - bd0) + (n_fd - fd0), 0);

        // saturation of the narrow counter
        cs_low();
        byte_vs_model("sat_byte");
        byte_vs_model("sat_byte");
        chk("sat_cnt_2", {30'h0, s_ucnt}, 32'd2);
        for (int k = 0; k < 3; k++) byte_vs_model("sat_byte");
        cs_high();
        chk("sat_cnt_max", {30'h0, s_ucnt}, 32'd3);
        chk("main_ucnt_after_sat", {16'h0, ucnt}, ur_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
